// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_ctrl_pkg;

  // Access size encodings carried on size_i.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } lsu_state_e;

  // Per-access control bits captured when an access is accepted.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       unsgn;
  } lsu_ctl_t;

  // Naturally aligned byte/half/word only; size 11 is reserved.
  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: access_legal = 1'b1;
      SZ_HALF: access_legal = ~lo[0];
      SZ_WORD: access_legal = (lo == 2'b00);
      default: access_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
interface lsu_ctrl_if #(parameter int XLEN = 32);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-enable / store-lane replication and load lane extract + extension.
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      lane,
  input  logic            unsgn,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wrep,
  output logic [XLEN-1:0] ld
);

  logic [7:0]  b;
  logic [15:0] h;

  // Select the addressed lane and build enables, replicated data and extended load.
  always_comb begin
    b    = rdata[{lane, 3'b000} +: 8];
    h    = rdata[{lane[1], 4'b0000} +: 16];
    be   = 4'b1111;
    wrep = wdata;
    ld   = rdata;
    case (size)
      SZ_BYTE: begin
        be   = 4'b0001 << lane;
        wrep = {(XLEN/8){wdata[7:0]}};
        ld   = {{(XLEN-8){b[7] & ~unsgn}}, b};
      end
      SZ_HALF: begin
        be   = 4'b0011 << {lane[1], 1'b0};
        wrep = {(XLEN/16){wdata[15:0]}};
        ld   = {{(XLEN-16){h[15] & ~unsgn}}, h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: memory handshake FSM, pipeline stall, timeout, load data register.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic [XLEN-1:0] dm_data_o,
  output logic            misalign_o,
  output logic            err_o,
  lsu_ctrl_if.master      bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e      state_q, state_d;
  lsu_ctl_t        ctl_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [CW-1:0]   cnt_q;
  logic            legal, tmo, ld_fire;
  logic [3:0]      be;
  logic [XLEN-1:0] wrep, ld;

  assign legal   = access_legal(size_i, addr_i[1:0]);
  assign tmo     = (cnt_q == CW'(TIMEOUT - 1));
  assign ld_fire = (state_q == S_WAIT) && bus.rvalid;

  lsu_align #(.XLEN(XLEN)) u_align (
    .size  (ctl_q.size),
    .lane  (addr_q[1:0]),
    .unsgn (ctl_q.unsgn),
    .wdata (wdata_q),
    .rdata (bus.rdata),
    .be    (be),
    .wrep  (wrep),
    .ld    (ld)
  );

  // Bus fields are driven only while requesting so they read zero otherwise.
  assign bus.we    = (state_q == S_REQ) & ctl_q.we;
  assign bus.addr  = (state_q == S_REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus.be    = (state_q == S_REQ) ? be : 4'b0000;
  assign bus.wdata = (state_q == S_REQ) ? wrep : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Capture the access when it is accepted out of IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == S_IDLE && req_i && legal) begin
      ctl_q   <= '{we: we_i, size: size_i, unsgn: unsigned_i};
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  // Timeout counter: zero while idle, counts each REQ/WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                                       cnt_q <= '0;
    else if (state_q == S_REQ || state_q == S_WAIT)   cnt_q <= cnt_q + 1'b1;
    else                                              cnt_q <= '0;
  end

  // Load result register: updated by a completed load, cleared by a timeout.
  always_ff @(posedge clk) begin
    if (!rst_n)       dm_data_o <= '0;
    else if (ld_fire) dm_data_o <= ld;
    else if (err_o)   dm_data_o <= '0;
  end

  // Next state and handshake outputs; gnt/rvalid win over a same-cycle timeout.
  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    err_o      = 1'b0;
    bus.req    = 1'b0;
    case (state_q)
      S_IDLE: if (req_i) begin
        if (legal) begin
          stall_o = 1'b1;
          state_d = S_REQ;
        end else begin
          misalign_o = 1'b1;
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        bus.req = 1'b1;
        if (bus.gnt)  state_d = ctl_q.we ? S_DONE : S_WAIT;
        else if (tmo) begin
          err_o   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (bus.rvalid) state_d = S_DONE;
        else if (tmo) begin
          err_o   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized accesses.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, misalign_o, err_o;
  logic [31:0] dm_data_o;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_dm = 32'h0;

  lsu_ctrl_if #(.XLEN(32)) bus();

  lsu_ctrl #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .stall_o    (stall_o),
    .dm_data_o  (dm_data_o),
    .misalign_o (misalign_o),
    .err_o      (err_o),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the access rules with plain arithmetic.
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int nb = 1 << sz;
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wrep(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {24'h0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'h0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    int nb = 1 << sz;
    longint unsigned mask = (64'd1 << (8 * nb)) - 1;
    longint unsigned v = ({32'h0, rd} >> (8 * (a % 4))) & mask;
    if (!uns && nb < 4 && v[8*nb-1]) v = v | (~mask);
    return v[31:0];
  endfunction

  task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
  endtask

  // Legal access: gd cycles without gnt, then gnt; for loads rd WAIT cycles, then rvalid.
  task automatic do_access(input string tag, input bit we, input logic [1:0] sz, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                           input int gd, input int rd);
    @(negedge clk);
    issue(we, sz, uns, a, wd);
    #1;
    chk({tag, ".idle_stall"}, 32'(stall_o), 32'd1);
    @(negedge clk);
    chk({tag, ".req"}, 32'(bus.req), 32'd1);
    chk({tag, ".addr"}, bus.addr, a & 32'hFFFF_FFFC);
    chk({tag, ".be"}, 32'(bus.be), 32'(m_be(sz, a)));
    chk({tag, ".we"}, 32'(bus.we), 32'(we));
    if (we) chk({tag, ".wdata"}, bus.wdata, m_wrep(sz, wd));
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      chk({tag, ".req_hold"}, {31'h0, bus.req, stall_o} == 32'd3 ? 32'd1 : 32'd0, 32'd1);
    end
    bus.gnt = 1'b1;
    #1;
    chk({tag, ".no_err_gnt"}, 32'(err_o), 32'd0);
    @(negedge clk);
    bus.gnt = 1'b0;
    if (!we) begin
      chk({tag, ".wait_noreq"}, 32'(bus.req), 32'd0);
      chk({tag, ".wait_stall"}, 32'(stall_o), 32'd1);
      for (int i = 0; i < rd; i++) @(negedge clk);
      bus.rvalid = 1'b1;
      bus.rdata  = rdv;
      #1;
      chk({tag, ".no_err_rv"}, 32'(err_o), 32'd0);
      @(negedge clk);
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      exp_dm = m_load(sz, uns, a, rdv);
    end
    chk({tag, ".done_stall"}, 32'(stall_o), 32'd0);
    chk({tag, ".dm"}, dm_data_o, exp_dm);
    req_i = 1'b0;
  endtask

  task automatic do_illegal(input string tag, input logic [1:0] sz, input logic [31:0] a);
    @(negedge clk);
    issue(1'b0, sz, 1'b0, a, 32'h0);
    #1;
    chk({tag, ".misalign"}, 32'(misalign_o), 32'd1);
    chk({tag, ".stall"}, 32'(stall_o), 32'd0);
    @(negedge clk);
    chk({tag, ".no_req"}, 32'(bus.req), 32'd0);
    req_i = 1'b0;
    #1;
    chk({tag, ".pulse_end"}, 32'(misalign_o), 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    bit          we, uns;

    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.req", 32'(bus.req), 32'd0);
    chk("rst.be", 32'(bus.be), 32'd0);
    chk("rst.err_mis", {30'h0, err_o, misalign_o}, 32'd0);
    chk("rst.dm", dm_data_o, 32'h0);
    rst_n = 1'b1;

    do_access("lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8000_00F0, 0, 0);
    chk("lw.value", dm_data_o, 32'h8000_00F0);
    do_access("lb", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 1, 2);
    chk("lb.value", dm_data_o, 32'hFFFF_FF80);
    do_access("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 0, 1);
    chk("lbu.value", dm_data_o, 32'h0000_0080);
    do_access("sh", 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0);
    do_illegal("lw_mis", 2'b10, 32'h101);
    do_illegal("rsvd", 2'b11, 32'h100);
    do_illegal("lh_mis", 2'b01, 32'h203);

    // Timeout: gnt on the first REQ cycle, rvalid never comes.
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    @(negedge clk);
    bus.gnt = 1'b1;
    @(negedge clk);
    bus.gnt = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      if (k == 15) chk("tmo.early", 32'(err_o), 32'd0);
      if (k == 16) chk("tmo.err", 32'(err_o), 32'd1);
      if (k < 16) @(negedge clk);
    end
    @(negedge clk);
    exp_dm = 32'h0;
    chk("tmo.stall_rel", 32'(stall_o), 32'd0);
    chk("tmo.err_pulse", 32'(err_o), 32'd0);
    chk("tmo.dm", dm_data_o, exp_dm);
    req_i = 1'b0;

    // Handshake completing on the very cycle the limit is reached wins.
    do_access("rv_at_limit", 1'b0, 2'b01, 1'b0, 32'h502, 32'h0, 32'hC001_5A5A, 0, 14);
    do_access("gnt_at_limit", 1'b1, 2'b10, 1'b0, 32'h600, 32'hCAFE_F00D, 32'h0, 15, 0);

    // Randomized legal accesses and a few illegal ones.
    for (int n = 0; n < 24; n++) begin
      sz  = 2'($urandom_range(0, 2));
      a   = $urandom & ~((32'd1 << sz) - 32'd1);
      we  = 1'($urandom);
      uns = 1'($urandom);
      do_access("rnd", we, sz, uns, a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    for (int n = 0; n < 4; n++) begin
      sz = 2'($urandom_range(1, 3));
      a  = $urandom | 32'h1;
      do_illegal("rnd_ill", sz, a);
    end

    // Reset during WAIT; a late rvalid afterwards must be ignored.
    do_access("pre_rst", 1'b0, 2'b10, 1'b0, 32'h700, 32'h0, 32'h1357_9BDF, 0, 0);
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h800, 32'h0);
    @(negedge clk);
    bus.gnt = 1'b1;
    @(negedge clk);
    bus.gnt = 1'b0;
    rst_n = 1'b0;
    req_i = 1'b0;
    @(negedge clk);
    exp_dm = 32'h0;
    chk("rst_mid.stall", 32'(stall_o), 32'd0);
    chk("rst_mid.req", 32'(bus.req), 32'd0);
    chk("rst_mid.dm", dm_data_o, exp_dm);
    rst_n = 1'b1;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.rvalid = 1'b0;
    chk("late_rv.dm", dm_data_o, exp_dm);
    chk("late_rv.stall", 32'(stall_o), 32'd0);
    do_access("post_rst", 1'b0, 2'b10, 1'b0, 32'h900, 32'h0, 32'h2468_ACE0, 1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
